// File: rtl/alu_step_sequencer.sv
// Control-step sequencer: fetches one instruction and walks the Datapath through T0..T6.
// Latency: 6 cycles T0..done for binary ops, 5 for NEG/NOT, 7 for MUL/DIV, plus T1 memory wait cycles.
// Backpressure: T1 holds until mem_ready; start is ignored while busy; run=1 chains instructions.
module alu_step_sequencer #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int OP_W   = 5,
  parameter int REG_W  = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              run,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] ir,
  output logic              PCout,
  output logic              MARin,
  output logic              IncPC,
  output logic              PCin,
  output logic              MDMuxread,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Yin,
  output logic              Zlowin,
  output logic              Zhighin,
  output logic              Zlowout,
  output logic              Zhighout,
  output logic              HIin,
  output logic              LOin,
  output logic [NREG-1:0]   Rin,
  output logic [NREG-1:0]   Rout,
  output logic [12:0]       alu_sel,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [3:0]        step
);

  localparam int LOW_W = DATA_W - OP_W - 3*REG_W;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7
  } state_t;

  // alu_sel bit positions
  localparam int SEL_MUL = 9;
  localparam int SEL_DIV = 10;
  localparam int SEL_NEG = 11;
  localparam int SEL_NOT = 12;

  state_t state, state_nxt;

  // Instruction fields copied at the T3 edge; T4..T6 never look at ir again.
  logic [12:0]      sel_q;
  logic [REG_W-1:0] ra_q;
  logic [REG_W-1:0] rc_q;
  logic             un_q;
  logic             md_q;
  logic             done_q;
  logic             last_step;

  // Live decode of ir, only meaningful in T3
  logic [OP_W-1:0]  op_d;
  logic [REG_W-1:0] ra_d;
  logic [REG_W-1:0] rb_d;
  logic [REG_W-1:0] rc_d;
  logic [12:0]      sel_d;
  logic             un_d;
  logic             bin_d;
  logic             bad_reg_d;
  logic             ill_d;

  assign op_d = ir[DATA_W-1 -: OP_W];
  assign ra_d = ir[DATA_W-OP_W-1 -: REG_W];
  assign rb_d = ir[DATA_W-OP_W-REG_W-1 -: REG_W];
  assign rc_d = ir[DATA_W-OP_W-2*REG_W-1 -: REG_W];

  generate
    if (LOW_W > 0) begin : g_low_bits
      logic unused_ir_low;
      assign unused_ir_low = ^ir[LOW_W-1:0];
    end
  endgenerate

  // Opcode to one-hot ALU select; all-zero means the opcode is not decodable.
  function automatic logic [12:0] op_to_sel(input logic [OP_W-1:0] op);
    logic [12:0] s;
    s = '0;
    case (op)
      OP_W'(3):  s[0]  = 1'b1;
      OP_W'(4):  s[1]  = 1'b1;
      OP_W'(5):  s[2]  = 1'b1;
      OP_W'(6):  s[3]  = 1'b1;
      OP_W'(7):  s[4]  = 1'b1;
      OP_W'(8):  s[5]  = 1'b1;
      OP_W'(9):  s[6]  = 1'b1;
      OP_W'(10): s[7]  = 1'b1;
      OP_W'(11): s[8]  = 1'b1;
      OP_W'(15): s[9]  = 1'b1;
      OP_W'(16): s[10] = 1'b1;
      OP_W'(17): s[11] = 1'b1;
      OP_W'(18): s[12] = 1'b1;
      default:   s     = '0;
    endcase
    return s;
  endfunction

  // Register index to one-hot strobe; out-of-range indices yield all zeros.
  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_W-1:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      v[i] = (int'(idx) == i);
    end
    return v;
  endfunction

  // Decode classification and legality of the instruction in ir
  always_comb begin
    sel_d     = op_to_sel(op_d);
    un_d      = sel_d[SEL_NEG] | sel_d[SEL_NOT];
    bin_d     = |sel_d[10:0];
    bad_reg_d = (int'(ra_d) >= NREG) || (int'(rb_d) >= NREG) ||
                (bin_d && (int'(rc_d) >= NREG));
    ill_d     = (sel_d == 13'd0) || bad_reg_d;
  end

  // State register
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture decoded fields at the T3 edge
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      sel_q <= '0;
      ra_q  <= '0;
      rc_q  <= '0;
      un_q  <= 1'b0;
      md_q  <= 1'b0;
    end else if (state == S_T3) begin
      sel_q <= sel_d;
      ra_q  <= ra_d;
      rc_q  <= rc_d;
      un_q  <= un_d;
      md_q  <= sel_d[SEL_MUL] | sel_d[SEL_DIV];
    end
  end

  // done is the registered image of the final step, so it lands one cycle later
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      done_q <= 1'b0;
    end else begin
      done_q <= last_step;
    end
  end

  // Next state and per-step control bundle
  always_comb begin
    state_nxt = state;
    last_step = 1'b0;
    PCout     = 1'b0;
    MARin     = 1'b0;
    IncPC     = 1'b0;
    PCin      = 1'b0;
    MDMuxread = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zlowin    = 1'b0;
    Zhighin   = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    Rin       = '0;
    Rout      = '0;
    alu_sel   = '0;
    illegal   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_T0;
      end
      S_T0: begin
        PCout     = 1'b1;
        MARin     = 1'b1;
        IncPC     = 1'b1;
        Zlowin    = 1'b1;
        state_nxt = S_T1;
      end
      S_T1: begin
        // Read strobes stay up while waiting; the PC update happens only on the ready cycle.
        MDMuxread = 1'b1;
        MDRin     = 1'b1;
        if (mem_ready) begin
          PCin      = 1'b1;
          Zlowout   = 1'b1;
          state_nxt = S_T2;
        end
      end
      S_T2: begin
        MDRout    = 1'b1;
        IRin      = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        if (ill_d) begin
          illegal   = 1'b1;
          state_nxt = S_IDLE;
        end else if (un_d) begin
          Rout      = reg_onehot(rb_d);
          alu_sel   = sel_d;
          Zlowin    = 1'b1;
          state_nxt = S_T4;
        end else begin
          Rout      = reg_onehot(rb_d);
          Yin       = 1'b1;
          state_nxt = S_T4;
        end
      end
      S_T4: begin
        if (un_q) begin
          Zlowout   = 1'b1;
          Rin       = reg_onehot(ra_q);
          last_step = 1'b1;
        end else begin
          Rout      = reg_onehot(rc_q);
          alu_sel   = sel_q;
          Zlowin    = 1'b1;
          Zhighin   = md_q;
          state_nxt = S_T5;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (md_q) begin
          LOin      = 1'b1;
          state_nxt = S_T6;
        end else begin
          Rin       = reg_onehot(ra_q);
          last_step = 1'b1;
        end
      end
      S_T6: begin
        Zhighout  = 1'b1;
        HIin      = 1'b1;
        last_step = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (last_step) begin
      state_nxt = run ? S_T0 : S_IDLE;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign step = state;

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Directed bench for alu_step_sequencer: per-instruction step table plus multi-cycle corner sequences.
// A second instance with NREG=8 covers the out-of-range register check.
module tb_alu_step_sequencer;

  localparam int K_BIN = 0;
  localparam int K_MD  = 1;
  localparam int K_UN  = 2;
  localparam int K_ILL = 3;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        start8 = 1'b0;
  logic        run = 1'b0;
  logic        mem_ready = 1'b1;
  logic [31:0] ir = 32'h0;

  logic a_PCout, a_MARin, a_IncPC, a_PCin, a_MDMuxread, a_MDRin, a_MDRout, a_IRin, a_Yin;
  logic a_Zlowin, a_Zhighin, a_Zlowout, a_Zhighout, a_HIin, a_LOin, a_busy, a_done, a_illegal;
  logic [15:0] a_Rin, a_Rout;
  logic [12:0] a_alu_sel;
  logic [3:0]  a_step;

  logic b_PCout, b_MARin, b_IncPC, b_PCin, b_MDMuxread, b_MDRin, b_MDRout, b_IRin, b_Yin;
  logic b_Zlowin, b_Zhighin, b_Zlowout, b_Zhighout, b_HIin, b_LOin, b_busy, b_done, b_illegal;
  logic [7:0]  b_Rin, b_Rout;
  logic [12:0] b_alu_sel;
  logic [3:0]  b_step;

  alu_step_sequencer #(.DATA_W(32), .NREG(16), .OP_W(5), .REG_W(4)) dut (
    .clock(clock), .clear(clear), .start(start), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(a_PCout), .MARin(a_MARin), .IncPC(a_IncPC), .PCin(a_PCin), .MDMuxread(a_MDMuxread),
    .MDRin(a_MDRin), .MDRout(a_MDRout), .IRin(a_IRin), .Yin(a_Yin), .Zlowin(a_Zlowin),
    .Zhighin(a_Zhighin), .Zlowout(a_Zlowout), .Zhighout(a_Zhighout), .HIin(a_HIin), .LOin(a_LOin),
    .Rin(a_Rin), .Rout(a_Rout), .alu_sel(a_alu_sel), .busy(a_busy), .done(a_done),
    .illegal(a_illegal), .step(a_step)
  );

  alu_step_sequencer #(.DATA_W(32), .NREG(8), .OP_W(5), .REG_W(4)) dut8 (
    .clock(clock), .clear(clear), .start(start8), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(b_PCout), .MARin(b_MARin), .IncPC(b_IncPC), .PCin(b_PCin), .MDMuxread(b_MDMuxread),
    .MDRin(b_MDRin), .MDRout(b_MDRout), .IRin(b_IRin), .Yin(b_Yin), .Zlowin(b_Zlowin),
    .Zhighin(b_Zhighin), .Zlowout(b_Zlowout), .Zhighout(b_Zhighout), .HIin(b_HIin), .LOin(b_LOin),
    .Rin(b_Rin), .Rout(b_Rout), .alu_sel(b_alu_sel), .busy(b_busy), .done(b_done),
    .illegal(b_illegal), .step(b_step)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic PCout, MARin, IncPC, PCin, MDMuxread, MDRin, MDRout, IRin, Yin;
    logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [12:0] alu_sel;
    logic busy, done, illegal;
    logic [3:0] step;
  } snap_t;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic [12:0] sel;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] rc;
    int          kind;
  } vec_t;

  int tests = 0;
  int fails = 0;

  function automatic snap_t cap(input bit use8);
    snap_t s;
    if (!use8) begin
      s = '{a_PCout, a_MARin, a_IncPC, a_PCin, a_MDMuxread, a_MDRin, a_MDRout, a_IRin, a_Yin,
            a_Zlowin, a_Zhighin, a_Zlowout, a_Zhighout, a_HIin, a_LOin, a_Rin, a_Rout,
            a_alu_sel, a_busy, a_done, a_illegal, a_step};
    end else begin
      s = '{b_PCout, b_MARin, b_IncPC, b_PCin, b_MDMuxread, b_MDRin, b_MDRout, b_IRin, b_Yin,
            b_Zlowin, b_Zhighin, b_Zlowout, b_Zhighout, b_HIin, b_LOin, {8'h0, b_Rin},
            {8'h0, b_Rout}, b_alu_sel, b_busy, b_done, b_illegal, b_step};
    end
    return s;
  endfunction

  // Expected bundle for one step of a given instruction, written straight from the step table.
  function automatic snap_t exp_step(input vec_t v, input int s);
    snap_t e;
    e = '0;
    e.step = 4'(s);
    e.busy = (s != 0);
    case (s)
      1: begin e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zlowin = 1; end
      2: begin e.MDMuxread = 1; e.MDRin = 1; e.PCin = 1; e.Zlowout = 1; end
      3: begin e.MDRout = 1; e.IRin = 1; end
      4: begin
        if (v.kind == K_ILL) e.illegal = 1;
        else if (v.kind == K_UN) begin e.Rout = v.rb; e.alu_sel = v.sel; e.Zlowin = 1; end
        else begin e.Rout = v.rb; e.Yin = 1; end
      end
      5: begin
        if (v.kind == K_UN) begin e.Zlowout = 1; e.Rin = v.ra; end
        else begin
          e.Rout = v.rc; e.alu_sel = v.sel; e.Zlowin = 1; e.Zhighin = (v.kind == K_MD);
        end
      end
      6: begin
        e.Zlowout = 1;
        if (v.kind == K_MD) e.LOin = 1;
        else e.Rin = v.ra;
      end
      7: begin e.Zhighout = 1; e.HIin = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic int last_of(input int kind);
    case (kind)
      K_ILL:   return 4;
      K_UN:    return 5;
      K_MD:    return 7;
      default: return 6;
    endcase
  endfunction

  task automatic check(input string name, input bit use8, input snap_t exp);
    snap_t act;
    act = cap(use8);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h (step got %0d want %0d)", name, act, exp, act.step, exp.step);
    end
  endtask

  function automatic snap_t idle_snap(input logic d);
    snap_t e;
    e = '0;
    e.done = d;
    return e;
  endfunction

  // Full instruction with mem_ready=1 and run=0: all steps, the done cycle, then quiet idle.
  task automatic run_instr(input vec_t v, input bit use8);
    int last;
    last = last_of(v.kind);
    ir = v.ir;
    @(negedge clock);
    if (use8) start8 = 1; else start = 1;
    for (int s = 1; s <= last; s++) begin
      @(negedge clock);
      start = 0;
      start8 = 0;
      check($sformatf("%s_T%0d", v.name, s - 1), use8, exp_step(v, s));
    end
    @(negedge clock);
    check($sformatf("%s_done", v.name), use8, idle_snap(v.kind != K_ILL));
    @(negedge clock);
    check($sformatf("%s_idle", v.name), use8, idle_snap(1'b0));
  endtask

  vec_t tbl[10];
  vec_t shr_v, add1_v, add2_v, ill8_v, add8_v;

  initial begin
    tbl[0] = '{"SHR",    32'h28918000, 13'h0004, 16'h0002, 16'h0004, 16'h0008, K_BIN};
    tbl[1] = '{"ADD",    32'h187B8000, 13'h0001, 16'h0001, 16'h8000, 16'h0080, K_BIN};
    tbl[2] = '{"OR",     32'h59080000, 13'h0100, 16'h0004, 16'h0002, 16'h0001, K_BIN};
    tbl[3] = '{"MUL",    32'h7A2B0000, 13'h0200, 16'h0010, 16'h0020, 16'h0040, K_MD};
    tbl[4] = '{"DIV",    32'h80918000, 13'h0400, 16'h0002, 16'h0004, 16'h0008, K_MD};
    tbl[5] = '{"NEG",    32'h89C80000, 13'h0800, 16'h0008, 16'h0200, 16'h0000, K_UN};
    tbl[6] = '{"NOT",    32'h97000000, 13'h1000, 16'h4000, 16'h0001, 16'h0000, K_UN};
    tbl[7] = '{"ILL31",  32'hF8000000, 13'h0000, 16'h0000, 16'h0000, 16'h0000, K_ILL};
    tbl[8] = '{"ILL0",   32'h00000000, 13'h0000, 16'h0000, 16'h0000, 16'h0000, K_ILL};
    tbl[9] = '{"ILL12",  32'h60000000, 13'h0000, 16'h0000, 16'h0000, 16'h0000, K_ILL};
    shr_v  = tbl[0];
    add1_v = tbl[1];
    add2_v = '{"ADD2",   32'h1AB38000, 13'h0001, 16'h0020, 16'h0040, 16'h0080, K_BIN};
    ill8_v = '{"ILL_RA9", 32'h1C800000, 13'h0000, 16'h0000, 16'h0000, 16'h0000, K_ILL};
    add8_v = '{"ADD8",   32'h18918000, 13'h0001, 16'h0002, 16'h0004, 16'h0008, K_BIN};

    // Reset state of both instances
    #12;
    check("reset_a", 1'b0, idle_snap(1'b0));
    check("reset_b", 1'b1, idle_snap(1'b0));
    @(negedge clock);
    clear = 1;

    // Table-driven instructions on the 16-register instance
    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i], 1'b0);
    end

    // NREG=8: register index 9 is illegal, a legal ADD still works
    run_instr(ill8_v, 1'b1);
    run_instr(add8_v, 1'b1);

    // Memory wait: three not-ready cycles in T1, then ready
    begin
      snap_t e;
      ir = shr_v.ir;
      mem_ready = 0;
      @(negedge clock);
      start = 1;
      @(negedge clock);
      start = 0;
      check("stall_T0", 1'b0, exp_step(shr_v, 1));
      for (int c = 0; c < 4; c++) begin
        @(negedge clock);
        mem_ready = (c == 3);
        #1;
        e = exp_step(shr_v, 2);
        e.PCin = (c == 3);
        e.Zlowout = (c == 3);
        check($sformatf("stall_T1_c%0d", c), 1'b0, e);
      end
      for (int s = 3; s <= 6; s++) begin
        @(negedge clock);
        check($sformatf("stall_T%0d", s - 1), 1'b0, exp_step(shr_v, s));
      end
      @(negedge clock);
      check("stall_done", 1'b0, idle_snap(1'b1));
    end

    // Back-to-back run mode with a stray start while busy
    begin
      snap_t e;
      run = 1;
      ir = add1_v.ir;
      @(negedge clock);
      start = 1;
      for (int s = 1; s <= 6; s++) begin
        @(negedge clock);
        start = (s == 4);
        if (s == 5) ir = add2_v.ir;
        check($sformatf("run1_T%0d", s - 1), 1'b0, exp_step(add1_v, s));
      end
      start = 0;
      @(negedge clock);
      run = 0;
      e = exp_step(add2_v, 1);
      e.done = 1;
      check("run2_T0_done", 1'b0, e);
      for (int s = 2; s <= 6; s++) begin
        @(negedge clock);
        check($sformatf("run2_T%0d", s - 1), 1'b0, exp_step(add2_v, s));
      end
      @(negedge clock);
      check("run2_done", 1'b0, idle_snap(1'b1));
      @(negedge clock);
      check("run2_idle", 1'b0, idle_snap(1'b0));
    end

    // Asynchronous clear during T4 of SHR
    begin
      ir = shr_v.ir;
      @(negedge clock);
      start = 1;
      for (int s = 1; s <= 5; s++) begin
        @(negedge clock);
        start = 0;
        check($sformatf("clr_T%0d", s - 1), 1'b0, exp_step(shr_v, s));
      end
      #1;
      clear = 0;
      #1;
      check("clr_async", 1'b0, idle_snap(1'b0));
      @(negedge clock);
      check("clr_held", 1'b0, idle_snap(1'b0));
      clear = 1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clock);
        check($sformatf("clr_after%0d", c), 1'b0, idle_snap(1'b0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

endmodule
